// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fetch_sequencer_pkg;

    // Sequencer states; encodings are fixed so debug probes can decode them.
    typedef enum logic [1:0] {
        FS_BOOT   = 2'd0,
        FS_RUN    = 2'd1,
        FS_DRAIN  = 2'd2,
        FS_HALTED = 2'd3
    } fs_state_t;

    // pc_src select values seen by the fetch datapath.
    localparam logic PC_SEL_INC = 1'b0;
    localparam logic PC_SEL_BR  = 1'b1;

    // Bundle of every control output the sequencer drives in a cycle.
    typedef struct packed {
        logic pc_en;
        logic pc_sel;
        logic ifid_en;
        logic flush_ifid;
        logic flush_idex;
        logic flush_exmem;
        logic fetch_valid;
        logic halted;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Width of the shared boot/drain down-counter: enough for the larger
    // load value (cycles - 1), never narrower than one bit.
    function automatic int seq_cnt_w(input int boot_cycles, input int drain_cycles);
        int max_load;
        int w;
        max_load = (boot_cycles > drain_cycles) ? boot_cycles - 1 : drain_cycles - 1;
        w = 1;
        while ((1 << w) <= max_load) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Handshake/control bundle between the fetch sequencer and the fetch datapath.
// Latency: n/a (wires only).
// Backpressure: stall_req from ID is the only hold-off; carried here as a level.
interface fetch_sequencer_if #(
    parameter int CNT_W = 32
);
    // Hazard / branch / halt inputs from ID and MEM
    logic             stall_req;
    logic             branch_taken;
    logic             halt_decoded;
    logic             resume;

    // Control outputs towards the fetch datapath and pipeline registers
    logic             pc_en;
    logic             pc_sel;
    logic             ifid_en;
    logic             flush_ifid;
    logic             flush_idex;
    logic             flush_exmem;
    logic             fetch_valid;
    logic             halted;

    // Performance counters
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Sequencer side
    modport master (
        input  stall_req, branch_taken, halt_decoded, resume,
        output pc_en, pc_sel, ifid_en, flush_ifid, flush_idex, flush_exmem,
        output fetch_valid, halted, cycle_cnt, stall_cnt, flush_cnt
    );

    // Pipeline / datapath side
    modport slave (
        output stall_req, branch_taken, halt_decoded, resume,
        input  pc_en, pc_sel, ifid_en, flush_ifid, flush_idex, flush_exmem,
        input  fetch_valid, halted, cycle_cnt, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter used for the sequencer performance counters.
// Latency: count reflects an inc one cycle after it is sampled.
// Backpressure: none; sticks at all-ones instead of wrapping.
module fetch_sequencer_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, clear on reset, hold once every bit is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control: PC hold/increment/redirect, IF/ID enable, flushes, boot and halt-drain.
// Latency: control outputs are Mealy (same cycle as inputs); state and counters update at the next edge.
// Backpressure: stall_req holds PC and IF/ID and bubbles ID/EX; a taken branch overrides it.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int BOOT_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);

    localparam int              SEQ_W      = seq_cnt_w(BOOT_CYCLES, DRAIN_CYCLES);
    localparam logic [SEQ_W-1:0] BOOT_LOAD  = SEQ_W'(BOOT_CYCLES - 1);
    localparam logic [SEQ_W-1:0] DRAIN_LOAD = SEQ_W'(DRAIN_CYCLES - 1);

    fs_state_t        state;
    logic [SEQ_W-1:0] seq_cnt;   // boot window in BOOT, remaining drain in DRAIN

    logic  branch_go;
    logic  halt_go;
    logic  stall_go;
    ctrl_t ctrl;

    // Which request wins this cycle: branch > halt > stall, each only in the
    // states that honour it. An older branch in DRAIN squashes the HALT.
    always_comb begin
        branch_go = 1'b0;
        halt_go   = 1'b0;
        stall_go  = 1'b0;
        if (!reset) begin
            branch_go = bus.branch_taken && ((state == FS_RUN) || (state == FS_DRAIN));
            halt_go   = (state == FS_RUN) && !bus.branch_taken && bus.halt_decoded;
            stall_go  = (state == FS_RUN) && !bus.branch_taken && !bus.halt_decoded
                        && bus.stall_req;
        end
    end

    // Mealy control outputs; everything is forced low while reset is asserted
    // so the datapath never sees a stray redirect during the reset cycle.
    always_comb begin
        ctrl        = CTRL_IDLE;
        ctrl.pc_sel = PC_SEL_INC;
        if (!reset) begin
            if (branch_go) begin
                ctrl.pc_en       = 1'b1;
                ctrl.pc_sel      = PC_SEL_BR;
                ctrl.ifid_en     = 1'b1;
                ctrl.flush_ifid  = 1'b1;
                ctrl.flush_idex  = 1'b1;
                ctrl.flush_exmem = 1'b1;
            end else begin
                unique case (state)
                    FS_BOOT: begin
                        ctrl = CTRL_IDLE;
                    end
                    FS_RUN: begin
                        if (halt_go) begin
                            ctrl.flush_ifid = 1'b1;
                        end else if (stall_go) begin
                            ctrl.flush_idex = 1'b1;
                        end else begin
                            ctrl.pc_en       = 1'b1;
                            ctrl.pc_sel      = PC_SEL_INC;
                            ctrl.ifid_en     = 1'b1;
                            ctrl.fetch_valid = 1'b1;
                        end
                    end
                    FS_DRAIN: begin
                        ctrl.flush_ifid = 1'b1;
                    end
                    FS_HALTED: begin
                        ctrl.halted = 1'b1;
                    end
                    default: begin
                        ctrl = CTRL_IDLE;
                    end
                endcase
            end
        end
    end

    // State machine and shared boot/drain down-counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FS_BOOT;
            seq_cnt <= BOOT_LOAD;
        end else begin
            unique case (state)
                FS_BOOT: begin
                    if (seq_cnt == '0) begin
                        state <= FS_RUN;
                    end else begin
                        seq_cnt <= seq_cnt - SEQ_W'(1);
                    end
                end
                FS_RUN: begin
                    if (halt_go) begin
                        state   <= FS_DRAIN;
                        seq_cnt <= DRAIN_LOAD;
                    end
                end
                FS_DRAIN: begin
                    if (branch_go) begin
                        state <= FS_RUN;
                    end else if (seq_cnt == '0) begin
                        state <= FS_HALTED;
                    end else begin
                        seq_cnt <= seq_cnt - SEQ_W'(1);
                    end
                end
                FS_HALTED: begin
                    if (bus.resume) begin
                        state <= FS_RUN;
                    end
                end
                default: begin
                    state <= FS_BOOT;
                end
            endcase
        end
    end

    fetch_sequencer_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (1'b1),
        .count (bus.cycle_cnt)
    );

    fetch_sequencer_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_go),
        .count (bus.stall_cnt)
    );

    fetch_sequencer_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (branch_go),
        .count (bus.flush_cnt)
    );

    assign bus.pc_en       = ctrl.pc_en;
    assign bus.pc_sel      = ctrl.pc_sel;
    assign bus.ifid_en     = ctrl.ifid_en;
    assign bus.flush_ifid  = ctrl.flush_ifid;
    assign bus.flush_idex  = ctrl.flush_idex;
    assign bus.flush_exmem = ctrl.flush_exmem;
    assign bus.fetch_valid = ctrl.fetch_valid;
    assign bus.halted      = ctrl.halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a 32-bit-counter DUT and a 4-bit-counter DUT share stimulus.
// Latency: inputs are applied just after a rising edge, outputs sampled on the following falling edge.
// Backpressure: n/a.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.CNT_W(32)) bus_a ();
    fetch_sequencer_if #(.CNT_W(4))  bus_b ();

    fetch_sequencer #(.BOOT_CYCLES(2), .DRAIN_CYCLES(3), .CNT_W(32)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    fetch_sequencer #(.BOOT_CYCLES(2), .DRAIN_CYCLES(3), .CNT_W(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int checks = 0;
    int errors = 0;

    // Expected control vectors, bit order:
    // {pc_en, pc_sel, ifid_en, flush_ifid, flush_idex, flush_exmem, fetch_valid, halted}
    localparam logic [7:0] C_OFF    = 8'b0000_0000;
    localparam logic [7:0] C_FETCH  = 8'b1010_0010;
    localparam logic [7:0] C_STALL  = 8'b0000_1000;
    localparam logic [7:0] C_BRANCH = 8'b1111_1100;
    localparam logic [7:0] C_HOLDIF = 8'b0001_0000;
    localparam logic [7:0] C_HALTED = 8'b0000_0001;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ctl_a();
        return {bus_a.pc_en, bus_a.pc_sel, bus_a.ifid_en, bus_a.flush_ifid,
                bus_a.flush_idex, bus_a.flush_exmem, bus_a.fetch_valid, bus_a.halted};
    endfunction

    function automatic logic [7:0] ctl_b();
        return {bus_b.pc_en, bus_b.pc_sel, bus_b.ifid_en, bus_b.flush_ifid,
                bus_b.flush_idex, bus_b.flush_exmem, bus_b.fetch_valid, bus_b.halted};
    endfunction

    // Both DUTs see identical stimulus, so their control outputs must agree.
    task automatic chk_ctl(input string tag, input logic [7:0] exp);
        chk({tag, "_a"}, {24'd0, ctl_a()}, {24'd0, exp});
        chk({tag, "_b"}, {24'd0, ctl_b()}, {24'd0, exp});
    endtask

    task automatic cyc(input logic rst, input logic st, input logic br,
                       input logic hl, input logic rs);
        @(posedge clk);
        #1;
        reset              = rst;
        bus_a.stall_req    = st;
        bus_a.branch_taken = br;
        bus_a.halt_decoded = hl;
        bus_a.resume       = rs;
        bus_b.stall_req    = st;
        bus_b.branch_taken = br;
        bus_b.halt_decoded = hl;
        bus_b.resume       = rs;
        @(negedge clk);
    endtask

    initial begin
        bus_a.stall_req = 1'b0; bus_a.branch_taken = 1'b0;
        bus_a.halt_decoded = 1'b0; bus_a.resume = 1'b0;
        bus_b.stall_req = 1'b0; bus_b.branch_taken = 1'b0;
        bus_b.halt_decoded = 1'b0; bus_b.resume = 1'b0;

        // Reset: outputs low even with requests asserted, counters cleared
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 1, 1, 0);
        chk_ctl("reset_ctl", C_OFF);
        chk("reset_cycle_cnt", bus_a.cycle_cnt, 32'd0);
        chk("reset_stall_cnt", bus_a.stall_cnt, 32'd0);
        chk("reset_flush_cnt", bus_a.flush_cnt, 32'd0);

        // Boot window: two cycles with inputs ignored, then first fetch
        cyc(0, 1, 1, 1, 0);
        chk_ctl("boot0_ctl", C_OFF);
        chk("boot0_cycle_cnt", bus_a.cycle_cnt, 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk_ctl("boot1_ctl", C_OFF);
        cyc(0, 0, 0, 0, 0);
        chk_ctl("first_fetch_ctl", C_FETCH);
        chk("first_fetch_cycle_cnt", bus_a.cycle_cnt, 32'd2);

        // Two stall cycles then normal fetch
        cyc(0, 1, 0, 0, 0);
        chk_ctl("stall0_ctl", C_STALL);
        chk("after_first_fetch_cycle_cnt", bus_a.cycle_cnt, 32'd3);
        cyc(0, 1, 0, 0, 0);
        chk_ctl("stall1_ctl", C_STALL);
        cyc(0, 0, 0, 0, 0);
        chk_ctl("post_stall_ctl", C_FETCH);
        chk("stall_cnt_2", bus_a.stall_cnt, 32'd2);

        // Branch beats a concurrent stall
        cyc(0, 1, 1, 0, 0);
        chk_ctl("branch_stall_ctl", C_BRANCH);
        cyc(0, 0, 0, 0, 0);
        chk_ctl("post_branch_ctl", C_FETCH);
        chk("branch_stall_cnt", bus_a.stall_cnt, 32'd2);
        chk("branch_flush_cnt", bus_a.flush_cnt, 32'd1);

        // Halt: one RUN cycle, three DRAIN cycles, then HALTED
        cyc(0, 0, 0, 1, 0);
        chk_ctl("halt_run_ctl", C_HOLDIF);
        cyc(0, 1, 0, 1, 0);
        chk_ctl("drain0_ctl", C_HOLDIF);
        cyc(0, 0, 0, 0, 0);
        chk_ctl("drain1_ctl", C_HOLDIF);
        chk("drain_stall_ignored", bus_a.stall_cnt, 32'd2);
        cyc(0, 0, 0, 0, 0);
        chk_ctl("drain2_ctl", C_HOLDIF);
        cyc(0, 0, 1, 0, 0);
        chk_ctl("halted_branch_ignored", C_HALTED);
        cyc(0, 0, 0, 0, 1);
        chk_ctl("halted_resume_cycle", C_HALTED);
        cyc(0, 0, 0, 0, 0);
        chk_ctl("resumed_ctl", C_FETCH);
        chk("halted_flush_cnt", bus_a.flush_cnt, 32'd1);

        // Branch on the second DRAIN cycle cancels the halt
        cyc(0, 0, 0, 1, 0);
        chk_ctl("halt2_run_ctl", C_HOLDIF);
        cyc(0, 0, 0, 0, 0);
        chk_ctl("halt2_drain0_ctl", C_HOLDIF);
        cyc(0, 0, 1, 0, 0);
        chk_ctl("drain_branch_ctl", C_BRANCH);
        cyc(0, 0, 0, 0, 0);
        chk_ctl("drain_branch_run_ctl", C_FETCH);
        chk("drain_branch_flush_cnt", bus_a.flush_cnt, 32'd2);
        chk("drain_branch_flush_cnt_b", {28'd0, bus_b.flush_cnt}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0);
            chk_ctl($sformatf("no_halt_%0d", i), C_FETCH);
        end

        // Saturation: 20 cycles after reset, 17 of them honoured stalls
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, (i < 19) ? 1'b1 : 1'b0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0);
        chk("sat_cycle_cnt_a", bus_a.cycle_cnt, 32'd20);
        chk("sat_stall_cnt_a", bus_a.stall_cnt, 32'd17);
        chk("sat_cycle_cnt_b", {28'd0, bus_b.cycle_cnt}, 32'd15);
        chk("sat_stall_cnt_b", {28'd0, bus_b.stall_cnt}, 32'd15);

        // Reset in the middle of DRAIN
        cyc(0, 0, 0, 1, 0);
        chk_ctl("halt3_run_ctl", C_HOLDIF);
        cyc(0, 0, 0, 0, 0);
        chk_ctl("halt3_drain0_ctl", C_HOLDIF);
        cyc(1, 0, 1, 0, 0);
        chk_ctl("reset_in_drain_ctl", C_OFF);
        cyc(0, 0, 0, 0, 0);
        chk_ctl("reboot0_ctl", C_OFF);
        chk("reboot_cycle_cnt_a", bus_a.cycle_cnt, 32'd0);
        chk("reboot_stall_cnt_a", bus_a.stall_cnt, 32'd0);
        chk("reboot_cycle_cnt_b", {28'd0, bus_b.cycle_cnt}, 32'd0);
        chk("reboot_stall_cnt_b", {28'd0, bus_b.stall_cnt}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk_ctl("reboot1_ctl", C_OFF);
        cyc(0, 0, 0, 0, 0);
        chk_ctl("reboot_fetch_ctl", C_FETCH);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
